// File: rtl/imm_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for imm_decode_stage.
// The master drives instructions in and accepts decoded entries; the slave is the stage.
interface imm_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] in_instr;
    logic            in_ready;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_imm_type;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_imm, out_imm_type, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_instr, out_imm, out_imm_type, out_illegal
    );
endinterface

// File: rtl/imm_decode_stage.sv
// RV32I decode slot: opcode classification, immediate generation and a registered pipeline slot.
// Define IMM_DECODE_SKID_EN to add a skid entry and a registered in_ready.
module sign_extend #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr,
    input  logic [2:0]      i_inst_type,
    output logic [XLEN-1:0] o_imm
);
    // Immediate assembly per RV32I format; unknown selects produce zero
    always_comb begin
        o_imm = '0;
        case (i_inst_type)
            3'b000:  o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            3'b001:  o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            3'b010:  o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            3'b011:  o_imm = {i_instr[31:12], 12'h000};
            3'b100:  o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end
endmodule

module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_decode_stage_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    // Returns {illegal, inst_type}
    function automatic logic [3:0] decode_opcode(input logic [6:0] op);
        logic [3:0] res;
        case (op)
            7'b1100011: res = {1'b0, 3'b000};
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: res = {1'b0, 3'b001};
            7'b0100011: res = {1'b0, 3'b010};
            7'b0110111,
            7'b0010111: res = {1'b0, 3'b011};
            7'b1101111: res = {1'b0, 3'b100};
            7'b0110011: res = {1'b0, 3'b111};
            default:    res = {1'b1, 3'b111};
        endcase
        return res;
    endfunction

    state_t          r_state;
    state_t          w_next_state;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_out;
    logic [3:0]      w_dec;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_src_instr;
    logic [XLEN-1:0] w_src_imm;
    logic [2:0]      w_src_type;
    logic            w_src_illegal;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_instr;
    logic [XLEN-1:0] r_out_imm;
    logic [2:0]      r_out_type;
    logic            r_out_illegal;

    assign w_dec = decode_opcode(bus.in_instr[6:0]);

    sign_extend #(.XLEN(XLEN)) u_sign_extend (
        .i_instr     (bus.in_instr),
        .i_inst_type (w_dec[2:0]),
        .o_imm       (w_imm)
    );

    assign w_accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_drain  = r_out_valid && bus.out_ready;

`ifdef IMM_DECODE_SKID_EN
    logic            r_in_ready;
    logic            w_load_skid;
    logic            w_out_from_skid;
    logic [XLEN-1:0] r_skid_instr;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_type;
    logic            r_skid_illegal;

    assign bus.in_ready = r_in_ready;

    // Next-state and load selection for the two-entry slot
    always_comb begin
        w_next_state    = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        if (bus.flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ST_FULL;
                        w_load_out   = 1'b1;
                    end else begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_drain) begin
                        w_next_state = ST_FULL;
                        w_load_out   = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = ST_SKID;
                        w_load_skid  = 1'b1;
                    end else if (w_drain) begin
                        w_next_state = ST_EMPTY;
                    end else begin
                        w_next_state = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (w_drain) begin
                        w_next_state    = ST_FULL;
                        w_load_out      = 1'b1;
                        w_out_from_skid = 1'b1;
                    end else begin
                        w_next_state = ST_SKID;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Output entry source: the older skid entry when draining from SKID
    always_comb begin
        if (w_out_from_skid) begin
            w_src_instr   = r_skid_instr;
            w_src_imm     = r_skid_imm;
            w_src_type    = r_skid_type;
            w_src_illegal = r_skid_illegal;
        end else begin
            w_src_instr   = bus.in_instr;
            w_src_imm     = w_imm;
            w_src_type    = w_dec[2:0];
            w_src_illegal = w_dec[3];
        end
    end

    // Skid entry storage and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b1;
            r_skid_instr   <= '0;
            r_skid_imm     <= '0;
            r_skid_type    <= 3'b111;
            r_skid_illegal <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state != ST_SKID);
            if (w_load_skid) begin
                r_skid_instr   <= bus.in_instr;
                r_skid_imm     <= w_imm;
                r_skid_type    <= w_dec[2:0];
                r_skid_illegal <= w_dec[3];
            end
        end
    end
`else
    // out_ready reaches in_ready combinationally so a full slot can refill while draining
    assign bus.in_ready = (r_state == ST_EMPTY) || bus.out_ready;

    // Next-state and load selection for the single slot
    always_comb begin
        w_next_state = r_state;
        w_load_out   = 1'b0;
        if (bus.flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ST_FULL;
                        w_load_out   = 1'b1;
                    end else begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        w_next_state = ST_FULL;
                        w_load_out   = 1'b1;
                    end else if (w_drain) begin
                        w_next_state = ST_EMPTY;
                    end else begin
                        w_next_state = ST_FULL;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    assign w_src_instr   = bus.in_instr;
    assign w_src_imm     = w_imm;
    assign w_src_type    = w_dec[2:0];
    assign w_src_illegal = w_dec[3];
`endif

    // Slot state and registered valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != ST_EMPTY);
        end
    end

    // Output entry data; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_instr   <= '0;
            r_out_imm     <= '0;
            r_out_type    <= 3'b111;
            r_out_illegal <= 1'b0;
        end else if (w_load_out) begin
            r_out_instr   <= w_src_instr;
            r_out_imm     <= w_src_imm;
            r_out_type    <= w_src_type;
            r_out_illegal <= w_src_illegal;
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_instr    = r_out_instr;
    assign bus.out_imm      = r_out_imm;
    assign bus.out_imm_type = r_out_type;
    assign bus.out_illegal  = r_out_illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed vectors plus randomized traffic
// compared against a queue-based reference of accepted instructions.
module tb_imm_decode_stage;
    logic clk = 1'b0;
    logic rst_n;

    imm_decode_stage_if bus ();

    imm_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q_instr [$];
    logic        last_hs;

    logic [31:0] b2b_in  [4] = '{32'h123452B7, 32'h00000463, 32'h00112223, 32'hFFDFF06F};
    logic [31:0] b2b_imm [4] = '{32'h12345000, 32'h00000008, 32'h00000004, 32'hFFFFFFFC};
    logic [2:0]  b2b_typ [4] = '{3'b011, 3'b000, 3'b010, 3'b100};
    logic [31:0] stall_in[4] = '{32'h00A00513, 32'hFE052EE3, 32'h00B12023, 32'h000012B7};
    logic [6:0]  ops     [12] = '{7'h63, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Immediate value from the RV32I field layout, using plain integer arithmetic
    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] t,
                                       output logic [31:0] imm, output logic ill);
        int unsigned u;
        u   = ins;
        t   = 3'd7;
        imm = 32'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h63: begin
                t   = 3'd0;
                imm = (((u >> 8) & 32'd15) << 1) + (((u >> 25) & 32'd63) << 5)
                    + (((u >> 7) & 32'd1) << 11) + (ins[31] ? 32'hFFFFF000 : 32'd0);
            end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                t   = 3'd1;
                imm = $unsigned($signed(ins) >>> 20);
            end
            7'h23: begin
                t   = 3'd2;
                imm = ((u >> 7) & 32'd31) + (((u >> 25) & 32'd127) << 5)
                    + (ins[31] ? 32'hFFFFF000 : 32'd0);
            end
            7'h37, 7'h17: begin
                t   = 3'd3;
                imm = u - (u % 32'd4096);
            end
            7'h6F: begin
                t   = 3'd4;
                imm = (((u >> 21) & 32'd1023) << 1) + (((u >> 20) & 32'd1) << 11)
                    + (((u >> 12) & 32'd255) << 12) + (ins[31] ? 32'hFFF00000 : 32'd0);
            end
            7'h33:   t   = 3'd7;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic check_out(input string tag);
        logic [2:0]  t;
        logic [31:0] imm;
        logic        ill;
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, q_instr.size() != 0});
        if (q_instr.size() != 0) begin
            ref_decode(q_instr[0], t, imm, ill);
            chk({tag, ".instr"}, bus.out_instr, q_instr[0]);
            chk({tag, ".imm"}, bus.out_imm, imm);
            chk({tag, ".type"}, {29'd0, bus.out_imm_type}, {29'd0, t});
            chk({tag, ".illegal"}, {31'd0, bus.out_illegal}, {31'd0, ill});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, ".instr"}, bus.out_instr, 32'd0);
        chk({tag, ".imm"}, bus.out_imm, 32'd0);
        chk({tag, ".type"}, {29'd0, bus.out_imm_type}, 32'd7);
        chk({tag, ".illegal"}, {31'd0, bus.out_illegal}, 32'd0);
    endtask

    // One clock: drive, check ready, advance the reference queue, check outputs
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy,
                         input logic fl, input string tag);
        logic exp_ready, acc, drn;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
`ifdef IMM_DECODE_SKID_EN
        exp_ready = (q_instr.size() < 2);
`else
        exp_ready = (q_instr.size() == 0) || rdy;
`endif
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_ready});
        acc     = v && exp_ready;
        drn     = (q_instr.size() != 0) && rdy;
        last_hs = v && bus.in_ready && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            q_instr.delete();
        end else begin
            if (drn) void'(q_instr.pop_front());
            if (acc) q_instr.push_back(ins);
        end
        check_out(tag);
    endtask

    initial begin
        int          n_acc;
        int          idx;
        int          exp_acc;
        logic        have_pend;
        logic        pv;
        logic [31:0] pins;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);

        cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0, "addi");
        chk("addi.valid_k", {31'd0, bus.out_valid}, 32'd1);
        chk("addi.imm_k", bus.out_imm, 32'hFFFFFFFF);
        chk("addi.type_k", {29'd0, bus.out_imm_type}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, b2b_in[i], 1'b1, 1'b0, "b2b");
            chk("b2b.instr_k", bus.out_instr, b2b_in[i]);
            chk("b2b.imm_k", bus.out_imm, b2b_imm[i]);
            chk("b2b.type_k", {29'd0, bus.out_imm_type}, {29'd0, b2b_typ[i]});
        end

        cycle(1'b1, 32'h002081B3, 1'b1, 1'b0, "rtype");
        chk("rtype.imm_k", bus.out_imm, 32'd0);
        chk("rtype.type_k", {29'd0, bus.out_imm_type}, 32'd7);
        chk("rtype.ill_k", {31'd0, bus.out_illegal}, 32'd0);
        cycle(1'b1, 32'h0000007F, 1'b1, 1'b0, "illegal");
        chk("illegal.type_k", {29'd0, bus.out_imm_type}, 32'd7);
        chk("illegal.ill_k", {31'd0, bus.out_illegal}, 32'd1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, "idle");

        // Back-pressure: five stalled cycles with input always valid
        n_acc = 0;
        idx   = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, stall_in[idx], 1'b0, 1'b0, "stall");
            if (last_hs) begin
                n_acc++;
                idx++;
            end
        end
`ifdef IMM_DECODE_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        chk("stall.accepts", n_acc, exp_acc);
        chk("stall.head_k", bus.out_instr, stall_in[0]);
        for (int i = 0; i < 6; i++) begin
            if (idx < 4) begin
                cycle(1'b1, stall_in[idx], 1'b1, 1'b0, "drain");
                if (last_hs) idx++;
            end else begin
                cycle(1'b0, 32'd0, 1'b1, 1'b0, "drain");
            end
        end

        // Flush while full with a new instruction offered
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0, "fill");
        cycle(1'b1, 32'h00200113, 1'b1, 1'b1, "flush");
        chk("flush.valid_k", {31'd0, bus.out_valid}, 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, "postflush");
        chk("postflush.valid_k", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset between edges
        cycle(1'b1, 32'hFFDFF06F, 1'b0, 1'b0, "prerst");
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        q_instr.delete();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;

        // Randomized traffic with stable-until-accepted input protocol
        have_pend = 1'b0;
        pv        = 1'b0;
        pins      = 32'd0;
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            logic fl;
            if (!have_pend) begin
                pv = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    pins = $urandom();
                end else begin
                    pins = {$urandom() >> 7, ops[$urandom_range(0, 11)]};
                end
                have_pend = pv;
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            cycle(pv, pins, rdy, fl, "rand");
            if (last_hs || fl) begin
                have_pend = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
